slc3_mem_arbiter: RTL and testbench

- Shares the single on-chip program/data SRAM between two requesters: the SLC-3 CPU memory port (CPU) and the program loader/debug port (LDR).
- Sequences every access over a fixed, parameterised memory latency and returns data through a one-cycle acknowledge.
- Sits between the CPU bus interface and the SRAM wrapper, below the memory-mapped I/O decode that serves switches and hex displays.

---
 rtl/slc3_mem_arbiter.sv | 135 +++++++++++++
 tb/tb_slc3_mem_arbiter.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/slc3_mem_arbiter.sv
// Purpose: shares one SRAM between the CPU port and the loader/debug port, round-robin on ties.
// Latency: mem_ce held LATENCY cycles; the ack pulses LATENCY edges after the request is sampled.
// Backpressure: requesters hold req until ack; while busy, requests wait and are arbitrated at the next IDLE edge.
module slc3_mem_arbiter #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int LATENCY = 2
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    input  logic              ldr_req,
    input  logic              ldr_we,
    input  logic [ADDR_W-1:0] ldr_addr,
    input  logic [DATA_W-1:0] ldr_wdata,
    output logic              ldr_ack,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic              grant_ldr,
    output logic              mem_ce,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    // The counter loads LATENCY-1 at grant, so a 4-bit counter covers the 1..15 range.
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              mem_ce_q, mem_ce_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              grant_ldr_q, grant_ldr_d;
    logic              last_grant_q, last_grant_d;   // 1 = loader won the last arbitration
    logic              pick_ldr;

    // Arbitration: a lone requester wins; on a tie the side that did not win last time goes.
    always_comb begin
        pick_ldr = ldr_req && (!cpu_req || !last_grant_q);
    end

    // Next-state and datapath: latch the winner at grant, count down the access, capture at the end.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        mem_ce_d     = mem_ce_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        rdata_d      = rdata_q;
        grant_ldr_d  = grant_ldr_q;
        last_grant_d = last_grant_q;
        unique case (state_q)
            IDLE: begin
                if (cpu_req || ldr_req) begin
                    state_d      = ACCESS;
                    cnt_d        = CNT_INIT;
                    mem_ce_d     = 1'b1;
                    mem_we_d     = pick_ldr ? ldr_we    : cpu_we;
                    mem_addr_d   = pick_ldr ? ldr_addr  : cpu_addr;
                    mem_wdata_d  = pick_ldr ? ldr_wdata : cpu_wdata;
                    grant_ldr_d  = pick_ldr;
                    last_grant_d = pick_ldr;
                end
            end
            ACCESS: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    // Writes return zero so a stale read value never looks like write data.
                    rdata_d  = mem_we_q ? '0 : mem_rdata;
                    mem_ce_d = 1'b0;
                    mem_we_d = 1'b0;
                    state_d  = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register with synchronous reset; the loader is marked as last winner so the CPU takes the first tie.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q      <= IDLE;
            cnt_q        <= 4'd0;
            mem_ce_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            rdata_q      <= '0;
            grant_ldr_q  <= 1'b0;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            mem_ce_q     <= mem_ce_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            rdata_q      <= rdata_d;
            grant_ldr_q  <= grant_ldr_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign cpu_ack   = (state_q == DONE) && !grant_ldr_q;
    assign ldr_ack   = (state_q == DONE) &&  grant_ldr_q;
    assign busy      = (state_q != IDLE);
    assign grant_ldr = grant_ldr_q;
    assign mem_ce    = mem_ce_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign rdata     = rdata_q;

endmodule

// File: tb/tb_slc3_mem_arbiter.sv
// Purpose: self-checking bench for slc3_mem_arbiter (LATENCY=2 main instance, LATENCY=1 side instance).
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: requesters hold req until their ack and drop it right after.
module tb_slc3_mem_arbiter;

    localparam int LAT = 2;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        sram_load;

    logic        cpu_req, cpu_we, ldr_req, ldr_we;
    logic [15:0] cpu_addr, cpu_wdata, ldr_addr, ldr_wdata;
    logic        cpu_ack, ldr_ack, busy, grant_ldr, mem_ce, mem_we;
    logic [15:0] rdata, mem_addr, mem_wdata, mem_rdata;

    logic        a_cpu_req, a_cpu_we, a_ldr_req, a_ldr_we;
    logic [15:0] a_cpu_addr, a_cpu_wdata, a_ldr_addr, a_ldr_wdata;
    logic        a_cpu_ack, a_ldr_ack, a_busy, a_grant_ldr, a_mem_ce, a_mem_we;
    logic [15:0] a_rdata, a_mem_addr, a_mem_wdata, a_mem_rdata;

    int n_pass = 0;
    int n_chk  = 0;

    always #5 Clk = ~Clk;

    slc3_mem_arbiter #(.ADDR_W(16), .DATA_W(16), .LATENCY(LAT)) u_dut (
        .Clk(Clk), .Reset(Reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack),
        .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata), .ldr_ack(ldr_ack),
        .rdata(rdata), .busy(busy), .grant_ldr(grant_ldr),
        .mem_ce(mem_ce), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    slc3_mem_arbiter #(.ADDR_W(16), .DATA_W(16), .LATENCY(1)) u_dut1 (
        .Clk(Clk), .Reset(Reset),
        .cpu_req(a_cpu_req), .cpu_we(a_cpu_we), .cpu_addr(a_cpu_addr), .cpu_wdata(a_cpu_wdata), .cpu_ack(a_cpu_ack),
        .ldr_req(a_ldr_req), .ldr_we(a_ldr_we), .ldr_addr(a_ldr_addr), .ldr_wdata(a_ldr_wdata), .ldr_ack(a_ldr_ack),
        .rdata(a_rdata), .busy(a_busy), .grant_ldr(a_grant_ldr),
        .mem_ce(a_mem_ce), .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata)
    );

    // Behavioural SRAM: combinational read, write on the edge while enabled.
    logic [15:0] sram [0:65535];
    assign mem_rdata   = sram[mem_addr];
    assign a_mem_rdata = a_mem_addr ^ 16'h0F0F;

    always @(posedge Clk) begin
        if (sram_load) begin
            for (int i = 0; i < 65536; i++) sram[i] <= 16'(i) ^ 16'hA5C3;
            sram[16'h3000] <= 16'h1234;
        end else if (mem_ce && mem_we) begin
            sram[mem_addr] <= mem_wdata;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic clear_inputs();
        cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
        ldr_req = 0; ldr_we = 0; ldr_addr = 0; ldr_wdata = 0;
        a_cpu_req = 0; a_cpu_we = 0; a_cpu_addr = 0; a_cpu_wdata = 0;
        a_ldr_req = 0; a_ldr_we = 0; a_ldr_addr = 0; a_ldr_wdata = 0;
    endtask

    task automatic do_reset();
        Reset = 1;
        clear_inputs();
        repeat (3) step();
        Reset = 0;
    endtask

    typedef struct packed {
        logic        ldr;
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic        chg;
        logic [15:0] exp;
    } vec_t;

    vec_t vt [0:6];

    // One isolated transaction on the main instance, checked for timing, ownership and data.
    task automatic run_txn(input vec_t v);
        int   n;
        logic got;
        int   ce_n, we_n;
        logic addr_ok;
        if (v.ldr) begin ldr_req = 1; ldr_we = v.we; ldr_addr = v.addr; ldr_wdata = v.wdata; end
        else       begin cpu_req = 1; cpu_we = v.we; cpu_addr = v.addr; cpu_wdata = v.wdata; end
        step();
        n = 0; got = 0; ce_n = 0; we_n = 0; addr_ok = 1;
        while (!got && n < 40) begin
            if (mem_ce) begin
                ce_n++;
                if (mem_we) we_n++;
                if (mem_addr !== v.addr) addr_ok = 0;
            end
            if (cpu_ack || ldr_ack) got = 1;
            else begin
                if (v.chg && n == 0) begin
                    if (v.ldr) ldr_addr = v.addr + 16'd1; else cpu_addr = v.addr + 16'd1;
                end
                step();
                n++;
            end
        end
        chk("txn_ack_seen", 32'(got), 32'd1);
        chk("txn_ack_latency", 32'(n), 32'(LAT));
        chk("txn_ack_owner", {30'd0, cpu_ack, ldr_ack}, v.ldr ? 32'd1 : 32'd2);
        chk("txn_grant_ldr", 32'(grant_ldr), 32'(v.ldr));
        chk("txn_rdata", 32'(rdata), 32'(v.exp));
        chk("txn_ce_cycles", 32'(ce_n), 32'(LAT));
        chk("txn_we_cycles", 32'(we_n), v.we ? 32'(LAT) : 32'd0);
        chk("txn_addr_stable", 32'(addr_ok), 32'd1);
        cpu_req = 0; ldr_req = 0;
        step();
        chk("txn_busy_after", 32'(busy), 32'd0);
        chk("txn_rdata_hold", 32'(rdata), 32'(v.exp));
    endtask

    logic [15:0] mm [0:7];

    initial begin
        int   who [0:3];
        int   at  [0:3];
        int   nacks, cyc;
        logic got;
        int   edge_n, m_next, e_e;
        logic m_last, e_g, e_we, started, in_acc, ack_now;
        logic [15:0] e_addr, e_wd, e_rd, m_hold;

        vt[0] = '{ldr: 0, we: 0, addr: 16'h3000, wdata: 16'h0000, chg: 0, exp: 16'h1234};
        vt[1] = '{ldr: 1, we: 1, addr: 16'h0040, wdata: 16'hBEEF, chg: 0, exp: 16'h0000};
        vt[2] = '{ldr: 0, we: 0, addr: 16'h0040, wdata: 16'h0000, chg: 0, exp: 16'hBEEF};
        vt[3] = '{ldr: 0, we: 0, addr: 16'h3000, wdata: 16'h0000, chg: 1, exp: 16'h1234};
        vt[4] = '{ldr: 1, we: 0, addr: 16'h3000, wdata: 16'h0000, chg: 0, exp: 16'h1234};
        vt[5] = '{ldr: 0, we: 1, addr: 16'h3001, wdata: 16'h5555, chg: 0, exp: 16'h0000};
        vt[6] = '{ldr: 1, we: 0, addr: 16'h3001, wdata: 16'h0000, chg: 0, exp: 16'h5555};

        Reset = 1; sram_load = 1;
        clear_inputs();
        step();
        sram_load = 0;
        do_reset();

        // Reset state
        chk("rst_mem_ce", 32'(mem_ce), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_acks", {30'd0, cpu_ack, ldr_ack}, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_grant_ldr", 32'(grant_ldr), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        chk("rst_rdata", 32'(rdata), 32'd0);

        // Directed transaction table
        for (int i = 0; i < 7; i++) run_txn(vt[i]);

        // Continuous contention: both re-request right after being served
        do_reset();
        cpu_req = 1; cpu_addr = 16'h3000; ldr_req = 1; ldr_addr = 16'h0040;
        nacks = 0; cyc = 0;
        for (int k = 0; k < 40 && nacks < 4; k++) begin
            step(); cyc++;
            if (cpu_ack || ldr_ack) begin
                who[nacks] = ldr_ack ? 1 : 0;
                at[nacks]  = cyc;
                nacks++;
                if (cpu_ack) cpu_req = 0; else ldr_req = 0;
            end else begin
                cpu_req = 1; ldr_req = 1;
            end
        end
        cpu_req = 0; ldr_req = 0;
        chk("cont_ack_count", 32'(nacks), 32'd4);
        if (nacks == 4) begin
            for (int i = 0; i < 4; i++) chk("cont_order", 32'(who[i]), 32'(i % 2));
            for (int i = 0; i < 3; i++) chk("cont_spacing", 32'(at[i+1] - at[i]), 32'(LAT + 2));
        end

        // Reset in the middle of an access
        do_reset();
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h3000;
        step();
        chk("mid_ce_start", 32'(mem_ce), 32'd1);
        step();
        Reset = 1; cpu_req = 0;
        step();
        chk("mid_ce_off", 32'(mem_ce), 32'd0);
        chk("mid_busy_off", 32'(busy), 32'd0);
        chk("mid_no_ack", {30'd0, cpu_ack, ldr_ack}, 32'd0);
        chk("mid_rdata", 32'(rdata), 32'd0);
        Reset = 0;
        got = 0;
        repeat (4) begin step(); if (cpu_ack || ldr_ack) got = 1; end
        chk("mid_no_late_ack", 32'(got), 32'd0);
        cpu_req = 1; ldr_req = 1; cpu_addr = 16'h3000; ldr_addr = 16'h0040;
        step();
        chk("mid_tie_grant", 32'(grant_ldr), 32'd0);
        chk("mid_tie_addr", 32'(mem_addr), 32'h3000);
        ldr_req = 0;
        got = 0;
        for (int k = 0; k < 10 && !got; k++) begin step(); if (cpu_ack) got = 1; end
        chk("mid_tie_ack", 32'(got), 32'd1);
        cpu_req = 0;
        step();

        // LATENCY=1 instance: single read
        a_cpu_req = 1; a_cpu_addr = 16'h1234;
        step();
        chk("l1_ce_first", 32'(a_mem_ce), 32'd1);
        chk("l1_no_ack_yet", 32'(a_cpu_ack), 32'd0);
        step();
        chk("l1_ack", 32'(a_cpu_ack), 32'd1);
        chk("l1_ce_dropped", 32'(a_mem_ce), 32'd0);
        chk("l1_rdata", 32'(a_rdata), 32'h1D3B);
        a_cpu_req = 0;
        step();
        chk("l1_idle", 32'(a_busy), 32'd0);

        // Randomized traffic against a transaction-level model
        do_reset();
        edge_n = 0; m_next = 1; m_last = 1; started = 0; m_hold = 0;
        e_e = 0; e_g = 0; e_we = 0; e_addr = 0; e_wd = 0; e_rd = 0;
        for (int i = 0; i < 8; i++) mm[i] = (16'h8000 + 16'(i)) ^ 16'hA5C3;
        for (int k = 0; k < 800; k++) begin
            @(posedge Clk);
            edge_n++;
            if (edge_n >= m_next && (cpu_req || ldr_req)) begin
                e_g     = (cpu_req && ldr_req) ? !m_last : ldr_req;
                m_last  = e_g;
                e_e     = edge_n;
                m_next  = edge_n + LAT + 2;
                started = 1;
                e_we    = e_g ? ldr_we    : cpu_we;
                e_addr  = e_g ? ldr_addr  : cpu_addr;
                e_wd    = e_g ? ldr_wdata : cpu_wdata;
                e_rd    = e_we ? 16'h0000 : mm[e_addr[2:0]];
                if (e_we) mm[e_addr[2:0]] = e_wd;
            end
            #1;
            in_acc  = started && (edge_n < e_e + LAT);
            ack_now = started && (edge_n == e_e + LAT);
            if (ack_now) m_hold = e_rd;
            chk("rnd_mem_ce", 32'(mem_ce), 32'(in_acc));
            chk("rnd_busy", 32'(busy), 32'(started && edge_n <= e_e + LAT));
            chk("rnd_cpu_ack", 32'(cpu_ack), 32'(ack_now && !e_g));
            chk("rnd_ldr_ack", 32'(ldr_ack), 32'(ack_now && e_g));
            chk("rnd_rdata", 32'(rdata), 32'(m_hold));
            if (started) chk("rnd_grant_ldr", 32'(grant_ldr), 32'(e_g));
            if (in_acc) begin
                chk("rnd_mem_addr", 32'(mem_addr), 32'(e_addr));
                chk("rnd_mem_we", 32'(mem_we), 32'(e_we));
            end
            if (ack_now) begin
                if (e_g) ldr_req = 0; else cpu_req = 0;
            end else begin
                if (!cpu_req && $urandom_range(0, 2) == 0) begin
                    cpu_req = 1; cpu_we = 1'($urandom_range(0, 1));
                    cpu_addr = 16'h8000 + 16'($urandom_range(0, 7)); cpu_wdata = 16'($urandom);
                end
                if (!ldr_req && $urandom_range(0, 2) == 0) begin
                    ldr_req = 1; ldr_we = 1'($urandom_range(0, 1));
                    ldr_addr = 16'h8000 + 16'($urandom_range(0, 7)); ldr_wdata = 16'($urandom);
                end
                if (in_acc && $urandom_range(0, 3) == 0) begin
                    if (e_g) ldr_addr = 16'h8000 + 16'($urandom_range(0, 7));
                    else     cpu_addr = 16'h8000 + 16'($urandom_range(0, 7));
                end
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
